alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: LAT, default 2, number of cycles the enable is held high before the ALU result is sampled (legal 1..15).
REQ-002 Parameter: W, default 4, operand/result width.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  in  1  upstream operand pair valid.
REQ-006 Port: in_ready  out  1  block accepts an operand pair.
REQ-007 Port: in_a  in  W  operand A.
REQ-008 Port: in_b  in  W  operand B.
REQ-009 Port: e  out  1  enable to the ALU operand gate.
REQ-010 Port: a  out  W  captured operand A to the gate.
REQ-011 Port: b  out  W  captured operand B to the gate.
REQ-012 Port: alu_r  in  W  ALU result returned from the datapath.
REQ-013 Port: alu_co  in  1  ALU carry-out.
REQ-014 Port: out_valid  out  1  result available.
REQ-015 Port: out_ready  in  1  downstream accepts result.
REQ-016 Port: out_r  out  W  registered result; out_co  out  1  registered carry.

Function
REQ-017 FSM states: IDLE, ISSUE, HOLD; all outputs driven from registers, none combinational from inputs.
REQ-018 IDLE: in_ready=1, e=0, out_valid=0; in_valid=1 at an edge captures in_a/in_b into a/b, loads counter with LAT-1, goes to ISSUE.
REQ-019 ISSUE: e=1, in_ready=0; counter decrements each edge; at the edge where counter=0, alu_r/alu_co are sampled into out_r/out_co and state goes to HOLD.
REQ-020 e is high for exactly LAT consecutive cycles per accepted operation.
REQ-021 a and b are 0 whenever e=0; they hold captured values throughout ISSUE.
REQ-022 HOLD: out_valid=1, e=0, in_ready=0; out_r/out_co stable; out_ready=1 at an edge returns to IDLE.
REQ-023 Minimum issue-to-issue interval is LAT+2 cycles (accept edge, LAT ISSUE cycles, one HOLD cycle with out_ready=1).
REQ-024 in_valid in ISSUE or HOLD is ignored; no operand is overwritten.
REQ-025 out_ready outside HOLD is ignored.
REQ-026 out_r/out_co retain the last sampled value in IDLE; only the ISSUE-exit edge updates them.
REQ-027 LAT=1: ISSUE lasts one cycle, sample on that cycle's closing edge.

Reset
REQ-028 rst_n=0 immediately forces IDLE, e=0, a=0, b=0, out_valid=0, out_r=0, out_co=0, counter=0, regardless of clock.
REQ-029 Reset asserted mid-ISSUE or mid-HOLD discards the operation; no result is ever presented for it.
REQ-030 First accept is possible at the first rising edge after rst_n deasserts.

Structure
REQ-031 Shared package alu_pkg holds the W default, the state enum (IDLE/ISSUE/HOLD) and the LAT bounds.
REQ-032 One sub-module, issue_cnt: 4-bit loadable down-counter with zero flag, instantiated once.

Verification
REQ-033 Reset then in_a=4'h3, in_b=4'h5, in_valid pulse, LAT=2 -> e high exactly 2 cycles with a=3,b=5; alu_r=4'h8 driven -> out_valid next cycle, out_r=8, out_co=0.
REQ-034 out_ready held 0 for 5 cycles in HOLD -> out_valid, out_r stay constant, in_ready=0, new in_valid ignored.
REQ-035 Back-to-back ops, in_valid and out_ready held 1, LAT=2 -> accepts every 4 cycles, results in order.
REQ-036 rst_n low on second ISSUE cycle -> e, a, b drop to 0 asynchronously, out_valid never asserts.
REQ-037 LAT=1, in_a=4'hF, in_b=4'h1, alu_r=0, alu_co=1 -> e high 1 cycle, out_r=0, out_co=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and limits for the ALU issue controller.
package alu_pkg;
   localparam int ALU_W   = 4;
   localparam int CNT_W   = 4;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } issue_state_t;
endpackage

// File: rtl/issue_cnt.sv
// Purpose: loadable down-counter with zero flag, times the ALU enable window.
// Latency: load/decrement visible one cycle after the edge.
// Backpressure: none; stops at zero.
module issue_cnt
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Purpose: captures an operand pair, gates it to the ALU for LAT cycles, registers the result.
// Latency: result valid LAT+1 cycles after the accept edge.
// Backpressure: in_ready low from accept until out_ready is seen in HOLD.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int LAT = 2,
   parameter int W   = ALU_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         e,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   input  logic [W-1:0] alu_r,
   input  logic         alu_co,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_r,
   output logic         out_co
);

   // Out-of-range LAT is clamped so the counter load never wraps.
   localparam int LAT_C = (LAT < LAT_MIN) ? LAT_MIN : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LAT_C - 1);

   issue_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic             cnt_zero;
   logic             cnt_load;
   logic             cnt_dec;

   assign cnt_load = (state == IDLE) && in_valid;
   assign cnt_dec  = (state == ISSUE);

   issue_cnt u_issue_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         e         <= 1'b0;
         a         <= '0;
         b         <= '0;
         out_valid <= 1'b0;
         out_r     <= '0;
         out_co    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a        <= in_a;
                  b        <= in_b;
                  e        <= 1'b1;
                  in_ready <= 1'b0;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               // Counter reaching zero marks the last enabled cycle.
               if (cnt_zero) begin
                  out_r     <= alu_r;
                  out_co    <= alu_co;
                  e         <= 1'b0;
                  a         <= '0;
                  b         <= '0;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               e         <= 1'b0;
               a         <= '0;
               b         <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   logic unused_cnt;
   assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: LAT=2 and LAT=1 instances, transaction model plus directed checks.
module tb_alu_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid [2];
   logic       in_ready [2];
   logic [3:0] in_a [2];
   logic [3:0] in_b [2];
   logic       e [2];
   logic [3:0] a [2];
   logic [3:0] b [2];
   logic [3:0] alu_r [2];
   logic       alu_co [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [3:0] out_r [2];
   logic       out_co [2];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.LAT(2), .W(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_a(in_a[0]), .in_b(in_b[0]), .e(e[0]), .a(a[0]), .b(b[0]),
      .alu_r(alu_r[0]), .alu_co(alu_co[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .out_r(out_r[0]), .out_co(out_co[0])
   );

   alu_issue_ctrl #(.LAT(1), .W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_a(in_a[1]), .in_b(in_b[1]), .e(e[1]), .a(a[1]), .b(b[1]),
      .alu_r(alu_r[1]), .alu_co(alu_co[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .out_r(out_r[1]), .out_co(out_co[1])
   );

   // Adder datapath stub; returns a distinctive value whenever the gate is closed.
   assign {alu_co[0], alu_r[0]} = e[0] ? ({1'b0, a[0]} + {1'b0, b[0]}) : 5'h1F;
   assign {alu_co[1], alu_r[1]} = e[1] ? ({1'b0, a[1]} + {1'b0, b[1]}) : 5'h1F;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction model: remaining enable cycles, held result, captured operands.
   int         m_left [2] = '{0, 0};
   bit         m_hold [2] = '{0, 0};
   logic [3:0] m_a [2] = '{4'h0, 4'h0};
   logic [3:0] m_b [2] = '{4'h0, 4'h0};
   logic [3:0] m_r [2] = '{4'h0, 4'h0};
   logic       m_co [2] = '{1'b0, 1'b0};

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_left[i] = 0; m_hold[i] = 0; m_a[i] = 0; m_b[i] = 0; m_r[i] = 0; m_co[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_left[i] > 0) begin
               m_left[i]--;
               if (m_left[i] == 0) begin
                  {m_co[i], m_r[i]} = {1'b0, m_a[i]} + {1'b0, m_b[i]};
                  m_hold[i] = 1;
               end
            end else if (m_hold[i]) begin
               if (out_ready[i]) m_hold[i] = 0;
            end else if (in_valid[i]) begin
               m_a[i] = in_a[i];
               m_b[i] = in_b[i];
               m_left[i] = (i == 0) ? 2 : 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic me;
         me = (m_left[i] > 0);
         chk($sformatf("cmp%0d e", i), e[i], me);
         chk($sformatf("cmp%0d a", i), a[i], me ? m_a[i] : 4'h0);
         chk($sformatf("cmp%0d b", i), b[i], me ? m_b[i] : 4'h0);
         chk($sformatf("cmp%0d in_ready", i), in_ready[i], !me && !m_hold[i]);
         chk($sformatf("cmp%0d out_valid", i), out_valid[i], m_hold[i]);
         chk($sformatf("cmp%0d out_r", i), out_r[i], m_r[i]);
         chk($sformatf("cmp%0d out_co", i), out_co[i], m_co[i]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] opa [4];
      logic [3:0] opb [4];
      logic [3:0] exp_r [4];
      logic       exp_co [4];
      int k, nrise, last_rise;
      logic prev_e;
      opa = '{4'h1, 4'h7, 4'h9, 4'h4};
      opb = '{4'h2, 4'h8, 4'h9, 4'h4};
      exp_r = '{4'h3, 4'hF, 4'h2, 4'h8};
      exp_co = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 0; in_a[i] = 0; in_b[i] = 0; out_ready[i] = 0;
      end
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset e", e[0], 1'b0);
      chk("reset a", a[0], 4'h0);
      chk("reset out_valid", out_valid[0], 1'b0);
      chk("reset out_r", out_r[0], 4'h0);
      chk("reset in_ready", in_ready[0], 1'b1);

      // Operands presented together with reset release: first edge must accept.
      #1 rst_n = 1'b1;
      in_a[0] = 4'h3; in_b[0] = 4'h5; in_valid[0] = 1;
      @(negedge clk);
      chk("op1 e cyc1", e[0], 1'b1);
      chk("op1 a", a[0], 4'h3);
      chk("op1 b", b[0], 4'h5);
      #1 in_valid[0] = 0;
      @(negedge clk);
      chk("op1 e cyc2", e[0], 1'b1);
      @(negedge clk);
      chk("op1 e off", e[0], 1'b0);
      chk("op1 out_valid", out_valid[0], 1'b1);
      chk("op1 out_r", out_r[0], 4'h8);
      chk("op1 out_co", out_co[0], 1'b0);

      // Stalled HOLD with a competing request.
      #1 in_valid[0] = 1; in_a[0] = 4'h9; in_b[0] = 4'h9;
      repeat (5) begin
         @(negedge clk);
         chk("hold out_valid", out_valid[0], 1'b1);
         chk("hold out_r", out_r[0], 4'h8);
         chk("hold in_ready", in_ready[0], 1'b0);
         chk("hold e", e[0], 1'b0);
      end
      #1 in_valid[0] = 0; out_ready[0] = 1;
      @(negedge clk);
      chk("release out_valid", out_valid[0], 1'b0);
      chk("release in_ready", in_ready[0], 1'b1);
      chk("idle keeps out_r", out_r[0], 4'h8);

      // Back-to-back stream.
      #1 in_a[0] = opa[0]; in_b[0] = opb[0]; in_valid[0] = 1;
      k = 0; nrise = 0; last_rise = 0; prev_e = 0;
      for (int c = 0; c < 40 && k < 4; c++) begin
         @(negedge clk);
         if (out_valid[0]) begin
            chk("b2b out_r", out_r[0], exp_r[k]);
            chk("b2b out_co", out_co[0], exp_co[k]);
            k++;
         end
         if (e[0] && !prev_e) begin
            if (nrise > 0) chk("b2b interval", c - last_rise, 4);
            last_rise = c;
            nrise++;
            prev_e = e[0];
            #1;
            if (nrise < 4) begin
               in_a[0] = opa[nrise]; in_b[0] = opb[nrise];
            end else begin
               in_valid[0] = 0;
            end
         end else begin
            prev_e = e[0];
         end
      end
      chk("b2b results", k, 4);
      chk("b2b accepts", nrise, 4);

      // Reset during the second enabled cycle.
      @(negedge clk);
      #1 in_a[0] = 4'h6; in_b[0] = 4'h6; in_valid[0] = 1;
      @(negedge clk);
      chk("abort e cyc1", e[0], 1'b1);
      #1 in_valid[0] = 0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort e async", e[0], 1'b0);
      chk("abort a async", a[0], 4'h0);
      chk("abort b async", b[0], 4'h0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("abort no out_valid", out_valid[0], 1'b0);
      end

      // LAT=1 instance with carry.
      #1 in_a[1] = 4'hF; in_b[1] = 4'h1; in_valid[1] = 1; out_ready[1] = 0;
      @(negedge clk);
      chk("lat1 e", e[1], 1'b1);
      chk("lat1 a", a[1], 4'hF);
      chk("lat1 b", b[1], 4'h1);
      #1 in_valid[1] = 0;
      @(negedge clk);
      chk("lat1 e off", e[1], 1'b0);
      chk("lat1 out_valid", out_valid[1], 1'b1);
      chk("lat1 out_r", out_r[1], 4'h0);
      chk("lat1 out_co", out_co[1], 1'b1);
      #1 out_ready[1] = 1;
      @(negedge clk);
      chk("lat1 idle out_valid", out_valid[1], 1'b0);
      chk("lat1 idle in_ready", in_ready[1], 1'b1);
      chk("lat1 keeps out_co", out_co[1], 1'b1);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
